// File: rtl/toggle_counter_if.sv
// toggle_counter_if: control/data bundle between a counter user and toggle_counter.
interface toggle_counter_if #(parameter int WIDTH = 4);
  logic en;
  logic load;
  logic tc;
  logic wrap;
  logic [1:0] mode;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  modport master(output en, mode, t, load, d, input q, tc, wrap);
  modport slave(input en, mode, t, load, d, output q, tc, wrap);
endinterface

// File: rtl/toggle_counter.sv
// toggle_counter: WIDTH-bit hold/toggle/up/down register with parallel load and wrap/saturate flags.
module toggle_counter #(
  parameter int WIDTH = 4,
  parameter bit SATURATE = 1'b0,
  parameter int RESET_VAL = 0
) (
  input logic clk,
  input logic rst,
  toggle_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;
  logic wrap;
  logic lim;
  always_comb begin
    lim = (bus.mode == 2'b10 && &q) || (bus.mode == 2'b11 && q == '0);
    nxt = bus.mode == 2'b01 ? q ^ bus.t :
          bus.mode == 2'b10 ? q + 1'b1 :
          bus.mode == 2'b11 ? q - 1'b1 : q;
  end
  // At a limit, wrapping falls out of modular add/sub; saturation just suppresses the update.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RV;
      wrap <= 1'b0;
    end else if (bus.load) begin
      q <= bus.d;
      wrap <= 1'b0;
    end else begin
      wrap <= bus.en && lim;
      if (bus.en && !(SATURATE && lim)) q <= nxt;
    end
  end
  assign bus.q = q;
  assign bus.tc = lim;
  assign bus.wrap = wrap;
endmodule

// File: tb/tb_toggle_counter.sv
// tb_toggle_counter: random and directed stimulus against a behavioural model for three configurations.
module tb_toggle_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] t = '0;
  logic [3:0] d = '0;
  int checks = 0;
  int errors = 0;
  bit mvalid = 1'b0;
  logic [31:0] mq [3];
  logic mw [3];
  localparam int unsigned MAXV [3] = '{15, 15, 1};
  localparam bit SATV [3] = '{1'b0, 1'b1, 1'b0};
  localparam int unsigned RSTV [3] = '{5, 5, 1};

  always #5 clk = ~clk;

  toggle_counter_if #(.WIDTH(4)) i0 ();
  toggle_counter_if #(.WIDTH(4)) i1 ();
  toggle_counter_if #(.WIDTH(1)) i2 ();
  assign {i0.en, i0.load, i0.mode, i0.t, i0.d} = {en, load, mode, t, d};
  assign {i1.en, i1.load, i1.mode, i1.t, i1.d} = {en, load, mode, t, d};
  assign {i2.en, i2.load, i2.mode, i2.t, i2.d} = {en, load, mode, t[0], d[0]};

  toggle_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(5)) dut0 (.clk(clk), .rst(rst), .bus(i0));
  toggle_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(5)) dut1 (.clk(clk), .rst(rst), .bus(i1));
  toggle_counter #(.WIDTH(1), .SATURATE(1'b0), .RESET_VAL(3)) dut2 (.clk(clk), .rst(rst), .bus(i2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rules on plain integers: returns {wrap, next q}.
  function automatic logic [32:0] model_next(input int unsigned q, input int unsigned mx, input bit sat);
    int unsigned msk;
    msk = (mx == 15) ? 32'(t) : 32'(t[0]);
    if (load) return {1'b0, ((mx == 15) ? 32'(d) : 32'(d[0]))};
    if (!en || mode == 2'd0) return {1'b0, q};
    if (mode == 2'd1) return {1'b0, q ^ msk};
    if (mode == 2'd2) return q == mx ? {1'b1, sat ? q : 32'd0} : {1'b0, q + 1};
    return q == 0 ? {1'b1, sat ? q : mx} : {1'b0, q - 1};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mq[k] <= RSTV[k] & MAXV[k];
        mw[k] <= 1'b0;
      end else begin
        {mw[k], mq[k]} <= model_next(mq[k], MAXV[k], SATV[k]);
      end
    end
    if (rst) mvalid <= 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] aq;
        logic aw;
        logic at;
        logic et;
        aq = k == 0 ? 32'(i0.q) : k == 1 ? 32'(i1.q) : 32'(i2.q);
        aw = k == 0 ? i0.wrap : k == 1 ? i1.wrap : i2.wrap;
        at = k == 0 ? i0.tc : k == 1 ? i1.tc : i2.tc;
        et = (mode == 2'd2 && mq[k] == MAXV[k]) || (mode == 2'd3 && mq[k] == 0);
        chk($sformatf("model_q%0d", k), aq, mq[k]);
        chk($sformatf("model_wrap%0d", k), 32'(aw), 32'(mw[k]));
        chk($sformatf("model_tc%0d", k), 32'(at), 32'(et));
      end
    end
  end

  task automatic step(input logic r, input logic l, input logic e, input logic [1:0] m,
                      input logic [3:0] tt, input logic [3:0] dd);
    {rst, load, en, mode, t, d} = {r, l, e, m, tt, dd};
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1, 1, 0, 2'd0, 4'h0, 4'hA);
    chk("rst_q", 32'(i0.q), 32'h5);
    chk("rst_wrap", 32'(i0.wrap), 0);
    chk("rst_trunc_w1", 32'(i2.q), 1);
    step(0, 0, 0, 2'd0, 4'h0, 4'h0);
    chk("rst_release_q", 32'(i0.q), 32'h5);
    step(0, 1, 0, 2'd0, 4'h0, 4'h0);
    step(0, 0, 1, 2'd1, 4'hA, 4'h0);
    chk("tog1", 32'(i0.q), 32'hA);
    step(0, 0, 1, 2'd1, 4'hA, 4'h0);
    chk("tog2", 32'(i0.q), 32'h0);
    step(0, 0, 1, 2'd1, 4'hA, 4'h0);
    chk("tog3", 32'(i0.q), 32'hA);
    chk("tog_tc", 32'(i0.tc), 0);
    step(0, 1, 0, 2'd0, 4'h0, 4'hE);
    step(0, 0, 1, 2'd2, 4'h0, 4'h0);
    chk("up_f", 32'(i0.q), 32'hF);
    chk("up_tc", 32'(i0.tc), 1);
    step(0, 0, 1, 2'd2, 4'h0, 4'h0);
    chk("up_wrap_q", 32'(i0.q), 0);
    chk("up_wrap", 32'(i0.wrap), 1);
    chk("up_sat_hold", 32'(i1.q), 32'hF);
    step(0, 0, 1, 2'd2, 4'h0, 4'h0);
    chk("up_after_q", 32'(i0.q), 1);
    chk("up_after_wrap", 32'(i0.wrap), 0);
    step(0, 1, 0, 2'd0, 4'h0, 4'h1);
    step(0, 0, 1, 2'd3, 4'h0, 4'h0);
    chk("dn_q0", 32'(i1.q), 0);
    chk("dn_tc", 32'(i1.tc), 1);
    step(0, 0, 1, 2'd3, 4'h0, 4'h0);
    chk("dn_sat_q", 32'(i1.q), 0);
    chk("dn_sat_wrap1", 32'(i1.wrap), 1);
    chk("dn_wrap_q", 32'(i0.q), 32'hF);
    step(0, 0, 1, 2'd3, 4'h0, 4'h0);
    chk("dn_sat_wrap2", 32'(i1.wrap), 1);
    step(0, 0, 0, 2'd3, 4'h0, 4'h0);
    chk("dn_en0_wrap", 32'(i1.wrap), 0);
    chk("dn_en0_q", 32'(i1.q), 0);
    step(0, 1, 1, 2'd2, 4'h0, 4'h7);
    step(0, 1, 1, 2'd2, 4'h0, 4'h3);
    chk("prio_load", 32'(i0.q), 3);
    step(1, 1, 1, 2'd2, 4'h0, 4'h9);
    chk("prio_rst_q", 32'(i0.q), 5);
    chk("prio_rst_wrap", 32'(i0.wrap), 0);
    step(0, 1, 0, 2'd2, 4'h0, 4'h0);
    step(0, 0, 1, 2'd2, 4'h0, 4'h0);
    chk("gate1", 32'(i0.q), 1);
    step(0, 0, 0, 2'd2, 4'h0, 4'h0);
    chk("gate2", 32'(i0.q), 1);
    step(0, 0, 1, 2'd2, 4'h0, 4'h0);
    chk("gate3", 32'(i0.q), 2);
    step(0, 0, 0, 2'd2, 4'h0, 4'h0);
    chk("gate4", 32'(i0.q), 2);
    step(0, 0, 1, 2'd3, 4'h0, 4'h0);
    chk("gate_down", 32'(i0.q), 1);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? 15 : $urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
